// File: rtl/game_tick_pkg.sv
// Shared state encoding and constants for the game tick receiver.
// The optional overrun counter is enabled with macro TICK_OVERRUN_CNT_EN.
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } tick_state_e;

    localparam int OVERRUN_W = 8;
    localparam logic [OVERRUN_W-1:0] OVERRUN_MAX = '1;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages clear on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/game_tick_receiver.sv
// Turns rising edges of an asynchronous game clock into valid/ready game steps with a watchdog.
// Macro TICK_OVERRUN_CNT_EN compiles in the saturating lost-tick counter.
module game_tick_receiver
    import game_tick_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 300000,
    parameter int FRAME_W        = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 game_clk,
    input  logic                 enable,
    output logic                 tick_valid,
    input  logic                 tick_ready,
    output logic [FRAME_W-1:0]   frame_cnt,
    output logic [OVERRUN_W-1:0] overrun_cnt,
    output logic                 fault,
    input  logic                 clear_fault,
    output logic [1:0]           state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // Handshake: tick_valid stays high until a cycle with tick_valid & tick_ready; the step is taken on that edge.
    logic               sync_out;
    logic               hist_q, hist_d;
    logic               rise;
    tick_state_e        state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tick_valid_q, tick_valid_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               handshake;
    logic               accept_en;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_in),
        .rst_n (reset_n),
        .d     (game_clk),
        .q     (sync_out)
    );

    always_comb begin
        hist_d = sync_out;
        rise   = sync_out & ~hist_q;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hist_q       <= 1'b0;
            wd_q         <= '0;
            tick_valid_q <= 1'b0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            wd_q         <= wd_d;
            tick_valid_q <= tick_valid_d;
            frame_q      <= frame_d;
        end
    end

    // An edge always restarts the watchdog, even on the cycle it would have expired.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    wd_d    = '0;
                end else if (rise) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_FAULT;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_FAULT: begin
                wd_d = '0;
                if (clear_fault) state_d = enable ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wd_d    = '0;
            end
        endcase
    end

    // Edges count only while staying in RUN; leaving RUN drops any pending step.
    always_comb begin
        accept_en    = (state_q == ST_RUN) && (state_d == ST_RUN);
        handshake    = tick_valid_q & tick_ready;
        tick_valid_d = tick_valid_q & ~handshake;
        frame_d      = frame_q;
        if (!accept_en) begin
            tick_valid_d = 1'b0;
        end else if (rise) begin
            tick_valid_d = 1'b1;
            if (!tick_valid_q || handshake) frame_d = frame_q + 1'b1;
        end
    end

    assign tick_valid = tick_valid_q;
    assign frame_cnt  = frame_q;
    assign fault      = (state_q == ST_FAULT);
    assign state_dbg  = state_q;

`ifdef TICK_OVERRUN_CNT_EN
    logic [OVERRUN_W-1:0] overrun_q, overrun_d;
    logic                 lost_tick;

    always_comb begin
        lost_tick = accept_en & rise & tick_valid_q & ~handshake;
        overrun_d = overrun_q;
        if (lost_tick && (overrun_q != OVERRUN_MAX)) overrun_d = overrun_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_game_tick_receiver.sv
// Bench for game_tick_receiver: directed table rows, hand-written corner sequences and
// random stimulus, every cycle scored against a behavioural model of the rules.
module tb_game_tick_receiver;
    import game_tick_pkg::*;

    localparam int S       = 2;
    localparam int TIMEOUT = 40;
    localparam int SB_W    = 26;

`ifdef TICK_OVERRUN_CNT_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic        clk_in;
    logic        reset_n;
    logic        game_clk;
    logic        enable;
    logic        tick_valid;
    logic        tick_ready;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;
    logic        fault;
    logic        clear_fault;
    logic [1:0]  state_dbg;

    game_tick_receiver #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FRAME_W        (16)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .game_clk    (game_clk),
        .enable      (enable),
        .tick_valid  (tick_valid),
        .tick_ready  (tick_ready),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt),
        .fault       (fault),
        .clear_fault (clear_fault),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "time limit expired");
    end

    // ---------------- scoreboard / model state ----------------
    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int pulse_cnt = 0;
    bit prev_tv = 1'b0;

    logic [SB_W-1:0] exp_q[$];

    int          m_mode;
    bit          m_pending;
    logic [15:0] m_frames;
    int          m_overruns;
    int          m_quiet;
    bit          gc_hist[$];
    bit          preload_req;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_pending   = 1'b0;
        m_frames    = '0;
        m_overruns  = 0;
        m_quiet     = 0;
        preload_req = 1'b0;
        gc_hist.delete();
        for (int i = 0; i <= S; i++) gc_hist.push_back(1'b0);
        exp_q.delete();
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present at the edge.
    task automatic model_step();
        bit rise_seen;
        bit hs;
        if (!reset_n) return;
        if (preload_req) begin
            m_frames    = 16'hFFFF;
            preload_req = 1'b0;
        end
        rise_seen = gc_hist[S-1] && !gc_hist[S];
        hs        = m_pending && tick_ready;
        case (m_mode)
            M_IDLE: begin
                m_pending = 1'b0;
                m_quiet   = 0;
                if (enable) m_mode = M_RUN;
            end
            M_RUN: begin
                if (!enable) begin
                    m_mode    = M_IDLE;
                    m_pending = 1'b0;
                    m_quiet   = 0;
                end else if (rise_seen) begin
                    if (m_pending && !hs) m_overruns = (m_overruns >= 255) ? 255 : m_overruns + 1;
                    else m_frames = m_frames + 16'd1;
                    m_pending = 1'b1;
                    m_quiet   = 0;
                end else if (m_quiet == TIMEOUT - 1) begin
                    m_mode    = M_FAULT;
                    m_pending = 1'b0;
                    m_quiet   = 0;
                end else begin
                    m_quiet = m_quiet + 1;
                    if (hs) m_pending = 1'b0;
                end
            end
            default: begin
                m_pending = 1'b0;
                if (clear_fault) begin
                    m_mode  = enable ? M_RUN : M_IDLE;
                    m_quiet = 0;
                end
            end
        endcase
        gc_hist.push_front(game_clk);
        void'(gc_hist.pop_back());
        exp_q.push_back({(m_mode == M_FAULT), m_pending,
                         (OVR_ON ? 8'(m_overruns) : 8'd0), m_frames});
    endtask

    task automatic check_sb();
        logic [SB_W-1:0] act;
        logic [SB_W-1:0] exp;
        bit              do_cmp;
        act    = {fault, tick_valid, overrun_cnt, frame_cnt};
        exp    = '0;
        do_cmp = 1'b1;
        if (!reset_n) exp = '0;
        else if (exp_q.size() == 0) do_cmp = 1'b0;
        else exp = exp_q.pop_front();
        if (do_cmp) begin
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL sb t=%0t {fault,valid,ovr,frame} got %h expected %h", $time, act, exp);
            end
        end
        if (tick_valid && tick_ready) hs_cnt++;
        if (tick_valid && !prev_tv) pulse_cnt++;
        prev_tv = tick_valid;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk_in);
        check_sb();
        @(posedge clk_in);
        model_step();
        #2;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        tick_ready  = 1'b0;
        game_clk    = 1'b0;
        clear_fault = 1'b0;
        model_reset();
        repeat (3) cyc();
        reset_n = 1'b1;
    endtask

    task automatic gc_periods(input int n);
        for (int k = 0; k < n; k++) begin
            game_clk = 1'b1;
            repeat (10) cyc();
            game_clk = 1'b0;
            repeat (10) cyc();
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_valid"}, tick_valid, 0);
        chk({tag, "_frame"}, frame_cnt, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
        chk({tag, "_fault"}, fault, 0);
        repeat (2) cyc();
        reset_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit ready;
        int periods;
        int exp_frame;
        int exp_ovr;
        int exp_hs;
        int exp_pulses;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int hs0;
        int p0;

        vecs[0] = '{1'b1, 5, 5, 0, 5, 5};
        vecs[1] = '{1'b0, 3, 1, (OVR_ON ? 2 : 0), 1, 1};
        vecs[2] = '{1'b0, 1, 1, 0, 1, 1};
        vecs[3] = '{1'b0, 5, 1, (OVR_ON ? 4 : 0), 1, 1};

        do_reset();
        chk("rst_valid", tick_valid, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_ovr", overrun_cnt, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", state_dbg, ST_IDLE);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            enable     = 1'b1;
            tick_ready = vecs[i].ready;
            repeat (2) cyc();
            hs0 = hs_cnt;
            p0  = pulse_cnt;
            gc_periods(vecs[i].periods);
            tick_ready = 1'b1;
            repeat (4) cyc();
            chk($sformatf("vec%0d_frame", i), frame_cnt, vecs[i].exp_frame);
            chk($sformatf("vec%0d_ovr", i), overrun_cnt, vecs[i].exp_ovr);
            chk($sformatf("vec%0d_hs", i), hs_cnt - hs0, vecs[i].exp_hs);
            chk($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
            chk($sformatf("vec%0d_fault", i), fault, 0);
            chk($sformatf("vec%0d_valid", i), tick_valid, 0);
        end

        // watchdog expiry, ignored edges while faulted, clear back to RUN
        do_reset();
        enable = 1'b1;
        repeat (40) cyc();
        chk("wd_no_early_fault", fault, 0);
        cyc();
        chk("wd_fault", fault, 1);
        chk("wd_valid", tick_valid, 0);
        game_clk = 1'b1;
        repeat (10) cyc();
        game_clk = 1'b0;
        repeat (10) cyc();
        chk("wd_edge_ignored", frame_cnt, 0);
        chk("wd_sticky", fault, 1);
        clear_fault = 1'b1;
        cyc();
        clear_fault = 1'b0;
        chk("wd_cleared", fault, 0);
        chk("wd_run", state_dbg, ST_RUN);
        tick_ready = 1'b1;
        repeat (3) cyc();
        gc_periods(1);
        repeat (4) cyc();
        chk("wd_next_edge", frame_cnt, 1);
        chk("wd_fault_after", fault, 0);

        // frame counter wrap and overrun saturation
        do_reset();
        enable     = 1'b1;
        tick_ready = 1'b1;
        repeat (5) cyc();
        @(negedge clk_in);
        check_sb();
        #1;
        force dut.frame_q = 16'hFFFF;
        preload_req = 1'b1;
        @(posedge clk_in);
        model_step();
        #2;
        release dut.frame_q;
        cyc();
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        gc_periods(1);
        repeat (3) cyc();
        chk("wrap_zero", frame_cnt, 0);
        tick_ready = 1'b0;
        gc_periods(301);
        chk("sat_ovr", overrun_cnt, OVR_ON ? 255 : 0);
        chk("sat_frame", frame_cnt, 1);
        chk("sat_valid_held", tick_valid, 1);
        tick_ready = 1'b1;
        repeat (3) cyc();
        chk("sat_consumed", tick_valid, 0);

        // asynchronous reset while a step is pending
        do_reset();
        enable     = 1'b1;
        tick_ready = 1'b0;
        repeat (2) cyc();
        game_clk = 1'b1;
        repeat (10) cyc();
        game_clk = 1'b0;
        repeat (4) cyc();
        chk("rst_pending_valid", tick_valid, 1);
        async_reset_pulse("arst");
        p0 = pulse_cnt;
        repeat (12) cyc();
        chk("arst_no_tick", pulse_cnt - p0, 0);
        chk("arst_frame_hold", frame_cnt, 0);
        tick_ready = 1'b1;
        gc_periods(1);
        repeat (4) cyc();
        chk("arst_next_tick", pulse_cnt - p0, 1);
        chk("arst_frame", frame_cnt, 1);

        // random stimulus against the model
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int hold;
            hold     = $urandom_range(1, 24);
            game_clk = ~game_clk;
            for (int j = 0; j < hold; j++) begin
                tick_ready  = ($urandom_range(0, 3) != 0);
                enable      = ($urandom_range(0, 40) != 0);
                clear_fault = ($urandom_range(0, 15) == 0);
                cyc();
            end
            if ($urandom_range(0, 60) == 0) async_reset_pulse("rnd_arst");
        end
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
